// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared status codes, block geometry and cat geometry for the game sequencer
package game_pkg;

    localparam logic [1:0] ST_PLAY    = 2'b00;
    localparam logic [1:0] ST_FAIL    = 2'b01;
    localparam logic [1:0] ST_WIN     = 2'b10;
    localparam logic [1:0] ST_INITIAL = 2'b11;

    typedef enum logic [1:0] {
        S_PLAY    = ST_PLAY,
        S_FAIL    = ST_FAIL,
        S_WIN     = ST_WIN,
        S_INITIAL = ST_INITIAL
    } state_t;

    localparam logic [11:0] TILE = 12'd32;

    localparam logic [11:0] BLK1_X    = 12'd480;
    localparam logic [11:0] BLK2_X    = 12'd640;
    localparam logic [11:0] BLK3_X    = 12'd704;
    localparam logic [11:0] BLK_TOP_Y = 12'd608;

    localparam logic [11:0] CAT_W        = 12'd32;
    localparam logic [11:0] CAT_BODY_OFF = 12'd8;
    localparam logic [11:0] CAT_H        = 12'd64;

    // Widening add so that coordinate sums near the top of the 12-bit range never wrap.
    function automatic logic [12:0] sum13(input logic [11:0] a, input logic [11:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

endpackage

// File: rtl/game_ctrl_if.sv
// rtl/game_ctrl_if.sv - bundle between cat physics, renderer and the game sequencer
interface game_ctrl_if;

    logic        frame_tick;
    logic        start_btn;
    logic [11:0] cat_x;
    logic [11:0] cat_y;
    logic [1:0]  game_status;
    logic        hit_unknown1;
    logic        hit_unknown2;
    logic        hit_unknown3;
    logic [1:0]  lives;
    logic        respawn;

    modport master (
        output frame_tick, start_btn, cat_x, cat_y,
        input  game_status, hit_unknown1, hit_unknown2, hit_unknown3, lives, respawn
    );

    modport slave (
        input  frame_tick, start_btn, cat_x, cat_y,
        output game_status, hit_unknown1, hit_unknown2, hit_unknown3, lives, respawn
    );

endinterface

// File: rtl/unknown_hit_det.sv
// rtl/unknown_hit_det.sv - combinational detector for the cat's head striking one unknown block from below
module unknown_hit_det
    import game_pkg::*;
(
    input  logic [11:0] i_cat_x,
    input  logic [11:0] i_cat_y,
    input  logic [11:0] i_prev_y,
    input  logic [11:0] i_blk_x,
    output logic        o_hit
);

    logic [12:0] w_head_y;
    logic [12:0] w_cat_right;
    logic [12:0] w_blk_right;
    logic [12:0] w_blk_bottom;
    logic        w_rising;
    logic        w_head_in_row;
    logic        w_overlap;

    assign w_head_y     = sum13(i_cat_y, CAT_BODY_OFF);
    assign w_cat_right  = sum13(i_cat_x, CAT_W);
    assign w_blk_right  = sum13(i_blk_x, TILE);
    assign w_blk_bottom = sum13(BLK_TOP_Y, TILE);

    // Screen y grows downward, so a shrinking y means the cat is moving up.
    assign w_rising      = (i_cat_y < i_prev_y);
    assign w_head_in_row = (w_head_y >= {1'b0, BLK_TOP_Y}) && (w_head_y < w_blk_bottom);
    assign w_overlap     = (w_cat_right > {1'b0, i_blk_x}) && ({1'b0, i_cat_x} < w_blk_right);

    assign o_hit = w_rising && w_head_in_row && w_overlap;

endmodule

// File: rtl/game_ctrl.sv
// rtl/game_ctrl.sv - game-flow sequencer: status FSM, lives, screen hold timer, respawn and sticky block hits
module game_ctrl
    import game_pkg::*;
#(
    parameter int LIVES       = 3,
    parameter int HOLD_FRAMES = 180,
    parameter int WIN_X       = 1600,
    parameter int FLOOR_Y     = 800
) (
    input  logic        clk,
    input  logic        rst_n,
    game_ctrl_if.slave  bus
);

    localparam logic [1:0]  LIVES_INIT = 2'(LIVES);
    localparam logic [15:0] HOLD_LOAD  = (HOLD_FRAMES < 1) ? 16'd1 : 16'(HOLD_FRAMES);
    localparam logic [12:0] WIN_X13    = 13'(WIN_X);
    localparam logic [12:0] FLOOR_Y13  = 13'(FLOOR_Y);

    logic        r_sync_meta;
    logic        r_sync_q;
    logic        r_btn_prev;
    logic [11:0] r_prev_y;
    state_t      r_state;
    logic [15:0] r_hold;
    logic [1:0]  r_lives;
    logic [2:0]  r_hits;
    logic        r_respawn;

    state_t      w_state_nxt;
    logic [15:0] w_hold_nxt;
    logic [1:0]  w_lives_nxt;
    logic [2:0]  w_hits_nxt;
    logic        w_respawn_nxt;
    logic        w_start_edge;
    logic        w_fall;
    logic        w_win;
    logic [2:0]  w_hit;

    unknown_hit_det u_hit1 (
        .i_cat_x  (bus.cat_x),
        .i_cat_y  (bus.cat_y),
        .i_prev_y (r_prev_y),
        .i_blk_x  (BLK1_X),
        .o_hit    (w_hit[0])
    );

    unknown_hit_det u_hit2 (
        .i_cat_x  (bus.cat_x),
        .i_cat_y  (bus.cat_y),
        .i_prev_y (r_prev_y),
        .i_blk_x  (BLK2_X),
        .o_hit    (w_hit[1])
    );

    unknown_hit_det u_hit3 (
        .i_cat_x  (bus.cat_x),
        .i_cat_y  (bus.cat_y),
        .i_prev_y (r_prev_y),
        .i_blk_x  (BLK3_X),
        .o_hit    (w_hit[2])
    );

    assign w_start_edge = r_sync_q && !r_btn_prev;
    assign w_fall       = sum13(bus.cat_y, CAT_H) >= FLOOR_Y13;
    assign w_win        = {1'b0, bus.cat_x} >= WIN_X13;

    // Button synchroniser and previous-row tracker run in every state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync_meta <= 1'b0;
            r_sync_q    <= 1'b0;
            r_btn_prev  <= 1'b0;
            r_prev_y    <= 12'd0;
        end else begin
            r_sync_meta <= bus.start_btn;
            r_sync_q    <= r_sync_meta;
            r_btn_prev  <= r_sync_q;
            if (bus.frame_tick) begin
                r_prev_y <= bus.cat_y;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_INITIAL;
            r_hold    <= 16'd0;
            r_lives   <= LIVES_INIT;
            r_hits    <= 3'b000;
            r_respawn <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_hold    <= w_hold_nxt;
            r_lives   <= w_lives_nxt;
            r_hits    <= w_hits_nxt;
            r_respawn <= w_respawn_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_hold_nxt    = r_hold;
        w_lives_nxt   = r_lives;
        w_hits_nxt    = r_hits;
        w_respawn_nxt = 1'b0;

        case (r_state)
            S_INITIAL: begin
                if (w_start_edge) begin
                    w_state_nxt   = S_PLAY;
                    w_lives_nxt   = LIVES_INIT;
                    w_hits_nxt    = 3'b000;
                    w_respawn_nxt = 1'b1;
                end
            end
            S_PLAY: begin
                if (bus.frame_tick) begin
                    if (w_fall) begin
                        w_state_nxt = S_FAIL;
                        w_hold_nxt  = HOLD_LOAD;
                        w_lives_nxt = (r_lives != 2'd0) ? (r_lives - 2'd1) : 2'd0;
                    end else begin
                        w_hits_nxt = r_hits | w_hit;
                        if (w_win) begin
                            w_state_nxt = S_WIN;
                            w_hold_nxt  = HOLD_LOAD;
                        end
                    end
                end
            end
            S_FAIL: begin
                if (bus.frame_tick) begin
                    if (r_hold <= 16'd1) begin
                        w_hold_nxt = 16'd0;
                        if (r_lives == 2'd0) begin
                            w_state_nxt = S_INITIAL;
                        end else begin
                            w_state_nxt   = S_PLAY;
                            w_respawn_nxt = 1'b1;
                        end
                    end else begin
                        w_hold_nxt = r_hold - 16'd1;
                    end
                end
            end
            S_WIN: begin
                if (bus.frame_tick) begin
                    if (r_hold <= 16'd1) begin
                        w_hold_nxt  = 16'd0;
                        w_state_nxt = S_INITIAL;
                    end else begin
                        w_hold_nxt = r_hold - 16'd1;
                    end
                end
            end
        endcase
    end

    assign bus.game_status  = r_state;
    assign bus.hit_unknown1 = r_hits[0];
    assign bus.hit_unknown2 = r_hits[1];
    assign bus.hit_unknown3 = r_hits[2];
    assign bus.lives        = r_lives;
    assign bus.respawn      = r_respawn;

endmodule

// File: tb/tb_game_ctrl.sv
// tb/tb_game_ctrl.sv - self-checking bench for game_ctrl against a per-frame reference model
module tb_game_ctrl;

    localparam int HF = 180;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    game_ctrl_if bus ();

    game_ctrl #(
        .LIVES       (3),
        .HOLD_FRAMES (HF),
        .WIN_X       (1600),
        .FLOOR_Y     (800)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: 0 PLAY, 1 FAIL, 2 WIN, 3 INITIAL; screen time counted in ticks spent.
    int       m_status;
    int       m_lives;
    logic [2:0] m_hits;
    int       m_screen_ticks;
    int       m_prev_y;
    logic     m_respawn;

    function automatic bit hit_rule(int x, int y, int py, int bx);
        return (y < py) && (y + 8 >= 608) && (y + 8 < 640) && (x + 32 > bx) && (x < bx + 32);
    endfunction

    task automatic model_reset();
        m_status = 3; m_lives = 3; m_hits = 3'b000; m_screen_ticks = 0; m_prev_y = 0; m_respawn = 1'b0;
    endtask

    task automatic model_frame(int x, int y);
        m_respawn = 1'b0;
        if (m_status == 0) begin
            if (y + 64 >= 800) begin
                m_status = 1;
                m_lives = (m_lives > 0) ? m_lives - 1 : 0;
                m_screen_ticks = 0;
            end else begin
                if (hit_rule(x, y, m_prev_y, 480)) m_hits[0] = 1'b1;
                if (hit_rule(x, y, m_prev_y, 640)) m_hits[1] = 1'b1;
                if (hit_rule(x, y, m_prev_y, 704)) m_hits[2] = 1'b1;
                if (x >= 1600) begin
                    m_status = 2;
                    m_screen_ticks = 0;
                end
            end
        end else if (m_status == 1 || m_status == 2) begin
            m_screen_ticks++;
            if (m_screen_ticks >= HF) begin
                if (m_status == 2 || m_lives == 0) m_status = 3;
                else begin
                    m_status = 0;
                    m_respawn = 1'b1;
                end
            end
        end
        m_prev_y = y;
    endtask

    task automatic frame(int x, int y);
        @(negedge clk);
        bus.cat_x = 12'(x);
        bus.cat_y = 12'(y);
        bus.frame_tick = 1'b1;
        @(negedge clk);
        bus.frame_tick = 1'b0;
        model_frame(x, y);
    endtask

    // Returns clocks from button edge to PLAY and respawn on that clock and the next one.
    task automatic press_start(output int lat, output logic rsp, output logic rsp2);
        lat = -1; rsp = 1'b0; rsp2 = 1'b1;
        @(negedge clk);
        bus.start_btn = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (lat > 0 && i == lat + 1) rsp2 = bus.respawn;
            if (lat < 0 && bus.game_status == 2'b00) begin
                lat = i;
                rsp = bus.respawn;
            end
        end
        bus.start_btn = 1'b0;
        repeat (3) @(negedge clk);
        if (m_status == 3) begin
            m_status = 0; m_lives = 3; m_hits = 3'b000;
        end
        m_respawn = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.frame_tick = 1'b0; bus.start_btn = 1'b0; bus.cat_x = 12'd0; bus.cat_y = 12'd0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        checks++;
        if (bus.game_status !== 2'b11) begin errors++; $display("FAIL reset_status got %b exp 11", bus.game_status); end
        checks++;
        if (bus.lives !== 2'd3) begin errors++; $display("FAIL reset_lives got %0d exp 3", bus.lives); end
        checks++;
        if ({bus.hit_unknown3, bus.hit_unknown2, bus.hit_unknown1, bus.respawn} !== 4'b0000) begin
            errors++; $display("FAIL reset_flags got %b exp 0000", {bus.hit_unknown3, bus.hit_unknown2, bus.hit_unknown1, bus.respawn});
        end
    endtask

    task automatic test_start();
        int lat; logic rsp; logic rsp2;
        press_start(lat, rsp, rsp2);
        checks++;
        if (lat !== 3) begin errors++; $display("FAIL start_latency got %0d exp 3", lat); end
        checks++;
        if (rsp !== 1'b1 || rsp2 !== 1'b0) begin errors++; $display("FAIL start_respawn got %b%b exp 10", rsp, rsp2); end
        checks++;
        if (bus.lives !== 2'd3 || {bus.hit_unknown3, bus.hit_unknown2, bus.hit_unknown1} !== 3'b000) begin
            errors++; $display("FAIL start_state lives %0d hits %b exp 3 000", bus.lives, {bus.hit_unknown3, bus.hit_unknown2, bus.hit_unknown1});
        end
    endtask

    task automatic test_hit();
        frame(470, 620);
        frame(470, 606);
        checks++;
        if ({bus.hit_unknown3, bus.hit_unknown2, bus.hit_unknown1} !== 3'b001) begin
            errors++; $display("FAIL hit_rising got %b exp 001", {bus.hit_unknown3, bus.hit_unknown2, bus.hit_unknown1});
        end
        frame(630, 606);
        frame(630, 620);
        checks++;
        if ({bus.hit_unknown3, bus.hit_unknown2, bus.hit_unknown1} !== 3'b001 || bus.game_status !== 2'b00) begin
            errors++; $display("FAIL hit_falling got %b st %b exp 001 00", {bus.hit_unknown3, bus.hit_unknown2, bus.hit_unknown1}, bus.game_status);
        end
    endtask

    task automatic fail_and_hold(string tag, int x);
        int bad = 0;
        frame(x, 740);
        checks++;
        if (bus.game_status !== 2'b01 || bus.lives !== 2'(m_lives)) begin
            errors++; $display("FAIL %s_enter st %b lives %0d exp 01 %0d", tag, bus.game_status, bus.lives, m_lives);
        end
        for (int t = 1; t < HF; t++) begin
            frame(500, 600);
            if (bus.game_status !== 2'b01 && bad == 0) bad = t;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL %s_hold left FAIL at tick %0d exp %0d", tag, bad, HF); end
        frame(500, 600);
        checks++;
        if (bus.game_status !== 2'(m_status) || bus.respawn !== m_respawn) begin
            errors++; $display("FAIL %s_exit st %b rsp %b exp %0d %b", tag, bus.game_status, bus.respawn, m_status, m_respawn);
        end
    endtask

    task automatic test_fall_respawn();
        fail_and_hold("fall1", 500);
        checks++;
        if (bus.game_status !== 2'b00 || bus.respawn !== 1'b1 || bus.hit_unknown1 !== 1'b1 || bus.lives !== 2'd2) begin
            errors++; $display("FAIL respawn st %b rsp %b hit1 %b lives %0d exp 00 1 1 2", bus.game_status, bus.respawn, bus.hit_unknown1, bus.lives);
        end
        @(negedge clk);
        checks++;
        if (bus.respawn !== 1'b0) begin errors++; $display("FAIL respawn_width got %b exp 0", bus.respawn); end
        m_respawn = 1'b0;
    endtask

    task automatic test_game_over();
        int lat; logic rsp; logic rsp2;
        fail_and_hold("fall2", 500);
        fail_and_hold("fall3", 500);
        checks++;
        if (bus.game_status !== 2'b11 || bus.lives !== 2'd0 || bus.respawn !== 1'b0) begin
            errors++; $display("FAIL game_over st %b lives %0d rsp %b exp 11 0 0", bus.game_status, bus.lives, bus.respawn);
        end
        press_start(lat, rsp, rsp2);
        checks++;
        if (lat !== 3 || bus.lives !== 2'd3 || {bus.hit_unknown3, bus.hit_unknown2, bus.hit_unknown1} !== 3'b000) begin
            errors++; $display("FAIL restart lat %0d lives %0d hits %b exp 3 3 000", lat, bus.lives, {bus.hit_unknown3, bus.hit_unknown2, bus.hit_unknown1});
        end
    endtask

    task automatic test_priority_win();
        int bad = 0;
        fail_and_hold("prio", 1600);
        frame(1600, 600);
        checks++;
        if (bus.game_status !== 2'b10) begin errors++; $display("FAIL win_enter got %b exp 10", bus.game_status); end
        @(negedge clk);
        bus.start_btn = 1'b1;
        repeat (6) @(negedge clk);
        bus.start_btn = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.game_status !== 2'b10 || bus.respawn !== 1'b0) begin
            errors++; $display("FAIL win_ignores_start st %b rsp %b exp 10 0", bus.game_status, bus.respawn);
        end
        for (int t = 1; t < HF; t++) begin
            frame(100, 600);
            if (bus.game_status !== 2'b10 && bad == 0) bad = t;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL win_hold left WIN at tick %0d exp %0d", bad, HF); end
        frame(100, 600);
        checks++;
        if (bus.game_status !== 2'b11 || bus.respawn !== 1'b0) begin
            errors++; $display("FAIL win_exit st %b rsp %b exp 11 0", bus.game_status, bus.respawn);
        end
    endtask

    task automatic test_random();
        int lat; logic rsp; logic rsp2;
        int x, y, r;
        logic [8:0] got, exp;
        for (int n = 0; n < 400; n++) begin
            if (m_status == 3) press_start(lat, rsp, rsp2);
            r = $urandom_range(0, 99);
            x = (r < 2) ? $urandom_range(1600, 1700) : $urandom_range(440, 760);
            r = $urandom_range(0, 99);
            y = (r < 3) ? $urandom_range(736, 900) : $urandom_range(560, 700);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            frame(x, y);
            got = {bus.game_status, bus.lives, bus.hit_unknown3, bus.hit_unknown2, bus.hit_unknown1, bus.respawn};
            exp = {2'(m_status), 2'(m_lives), m_hits, m_respawn};
            checks++;
            if (got !== exp) begin
                errors++; $display("FAIL random_frame %0d x %0d y %0d got %b exp %b", n, x, y, got, exp);
            end
        end
    endtask

    task automatic test_async_reset();
        int lat; logic rsp; logic rsp2;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        press_start(lat, rsp, rsp2);
        frame(500, 740);
        repeat (10) frame(500, 600);
        checks++;
        if (bus.game_status !== 2'b01) begin errors++; $display("FAIL async_pre st %b exp 01", bus.game_status); end
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.game_status !== 2'b11 || bus.lives !== 2'd3 || bus.respawn !== 1'b0 ||
            {bus.hit_unknown3, bus.hit_unknown2, bus.hit_unknown1} !== 3'b000) begin
            errors++; $display("FAIL async_reset st %b lives %0d rsp %b hits %b exp 11 3 0 000", bus.game_status, bus.lives,
                bus.respawn, {bus.hit_unknown3, bus.hit_unknown2, bus.hit_unknown1});
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        test_reset();
        test_start();
        test_hit();
        test_fall_respawn();
        test_game_over();
        test_priority_win();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
